rd_rsp_route: RTL and testbench
===============================

RD_RSP_ROUTE -- requirements
Module: rd_rsp_route

Interface
REQ-001 SHALL have parameter PARAM, default 32, data width of every R data path.
REQ-002 SHALL have parameter DEPTH, default 8, number of outstanding read bursts tracked (power of two, 2..16).
REQ-003 SHALL have ports CLK_i in 1 (sole clock); RST_i in 1 (reset, asynchronous, active-high).
REQ-004 SHALL have ports ENABLE_i in 1 (AIDC compression enable, sampled per AR).
REQ-005 SHALL have ports ARVALID_i in 1, ARREADY_i in 1 (engine/XHB AR handshake); ARVALID_o out 1 and ARREADY_o out 1 (gated copies).
REQ-006 SHALL have ports RVALID_i in 1, RDATA_i in PARAM, RLAST_i in 1, RREADY_o out 1 (R channel from XHB).
REQ-007 SHALL have ports ERVALID_o out 1, ERDATA_o out PARAM, ERLAST_o out 1, ERREADY_i in 1 (enabled R to AIDC).
REQ-008 SHALL have ports CRVALID_i in 1, CRDATA_i in PARAM, CRLAST_i in 1, CRREADY_o out 1 (decompressed R from AIDC).
REQ-009 SHALL have ports RVALID_o out 1, RDATA_o out PARAM, RLAST_o out 1, RREADY_i in 1 (final R to engine).
REQ-010 SHALL have ports STAT_CMP_o out 16, STAT_BYP_o out 16 (burst counters, see Configuration).

Function
REQ-011 SHALL hold a tag FIFO of DEPTH 1-bit entries (1 = compressed, 0 = bypass) with write pointer, ingress read pointer (IRP), egress read pointer (ERP), each one bit wider than the index for wrap detection.
REQ-012 SHALL set full when WP and ERP differ only in the MSB; ARVALID_o = ARVALID_i & ~full; ARREADY_o = ARREADY_i & ~full.
REQ-013 SHALL push ENABLE_i at WP on ARVALID_o & ARREADY_i; an ENABLE_i change affects only later ARs.
REQ-014 SHALL stall XHB (RREADY_o=0) when IRP==WP (no outstanding burst); unsolicited beats never reach either output.
REQ-015 Ingress tag 1: SHALL forward RDATA_i/RLAST_i to ER*, ERVALID_o = RVALID_i, RREADY_o = ERREADY_i, combinationally.
REQ-016 Ingress tag 0: SHALL forward RDATA_i/RLAST_i to R*_o only when IRP==ERP (no compressed burst ahead); otherwise RREADY_o=0 and RVALID_o=0 on that path.
REQ-017 SHALL advance IRP on RVALID_i & RREADY_o & RLAST_i.
REQ-018 Egress head tag 1: SHALL drive R*_o from CR*_i, CRREADY_o = RREADY_i; CRREADY_o=0 otherwise.
REQ-019 SHALL advance ERP on the engine-side RLAST beat accepted (RVALID_o & RREADY_i & RLAST_o), for both tags; ERP never passes IRP for tag 0 or WP for tag 1.
REQ-020 SHALL accept push and both pops in one cycle; full is evaluated before the push (no push-through when full).
REQ-021 SHALL be zero-latency combinational on all data paths; only pointers and counters are registered.

Reset
REQ-022 SHALL on RST_i asynchronously clear WP, IRP, ERP, FIFO contents and counters; ARVALID_o, RREADY_o, ERVALID_o, CRREADY_o and RVALID_o read 0 during reset.
REQ-023 SHALL discard any in-flight burst on mid-operation reset; no beat is forwarded in the first cycle after release.

Configuration
REQ-024 With CONNECT_RD_STAT_EN defined, SHALL count completed bursts at ERP advance into STAT_CMP_o (tag 1) and STAT_BYP_o (tag 0), 16-bit saturating at 0xFFFF.
REQ-025 Without CONNECT_RD_STAT_EN, SHALL tie STAT_CMP_o and STAT_BYP_o to 0 and synthesise no counter flops.

Structure
REQ-026 SHALL take PARAM, DEPTH defaults and the tag encoding (TAG_BYP=0, TAG_CMP=1) from shared package connect_pkg.
REQ-027 SHALL instantiate one sub-module rd_tag_fifo (storage, three pointers, full/empty flags); routing and muxing stay in rd_rsp_route.

Verification
REQ-028 ENABLE_i=0, one AR, 4-beat R 0x1..0x4 -> same beats on R*_o in order, ERVALID_o never 1, STAT_BYP_o=1.
REQ-029 ENABLE_i=1, one AR, 4-beat R -> beats on ER*; CR 0xA..0xD with 3-cycle delay -> appear on R*_o; STAT_CMP_o=1.
REQ-030 AR compressed then AR bypass, bypass R returned while CR pending -> RREADY_o held 0 until CRLAST accepted, then bypass beats pass.
REQ-031 8 ARs with no R -> ARREADY_o=0 on 9th; one burst completes at egress -> 9th AR accepted next cycle.
REQ-032 RVALID_i=1 with no outstanding AR -> RREADY_o=0, RVALID_o=0, ERVALID_o=0 indefinitely.
REQ-033 RST_i asserted mid-burst beat 2 of 4 -> all outputs 0 immediately, pointers 0, counters 0 after release.

Source files
------------

// File: rtl/connect_pkg.sv
// Shared definitions for the read-response routing slice: default widths,
// the compression tag encoding and a saturating counter helper.
package connect_pkg;

    localparam int PARAM_DEF = 32;
    localparam int DEPTH_DEF = 8;

    // Per-burst routing tag: compressed bursts detour through AIDC.
    typedef enum logic {
        TAG_BYP = 1'b0,
        TAG_CMP = 1'b1
    } tag_e;

    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == STAT_MAX) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rd_tag_fifo.sv
// Tag FIFO for outstanding read bursts. One write pointer (AR side) and two
// read pointers: the ingress pointer follows XHB R bursts, the egress pointer
// follows bursts delivered to the engine. Pointers carry an extra wrap bit.
module rd_tag_fifo
    import connect_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  tag_e push_tag,
    input  logic in_pop,
    input  logic eg_pop,
    output logic full,
    output logic in_empty,
    output logic eg_empty,
    output logic in_eg_same,
    output tag_e in_tag,
    output tag_e eg_tag
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] PTR_ZERO = {(AW + 1){1'b0}};

    logic [AW:0] wp_r;
    logic [AW:0] irp_r;
    logic [AW:0] erp_r;
    tag_e        mem_r [DEPTH];

    // The egress pointer is the oldest live entry, so it bounds the free space.
    assign full       = (wp_r[AW] != erp_r[AW]) && (wp_r[AW-1:0] == erp_r[AW-1:0]);
    assign in_empty   = (irp_r == wp_r);
    assign eg_empty   = (erp_r == wp_r);
    assign in_eg_same = (irp_r == erp_r);
    assign in_tag     = mem_r[irp_r[AW-1:0]];
    assign eg_tag     = mem_r[erp_r[AW-1:0]];

    // Storage and pointer update; full is sampled before the push so a push
    // never lands in a slot that the same-cycle egress pop is freeing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_r  <= PTR_ZERO;
            irp_r <= PTR_ZERO;
            erp_r <= PTR_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= TAG_BYP;
            end
        end else begin
            if (push && !full) begin
                mem_r[wp_r[AW-1:0]] <= push_tag;
                wp_r                <= wp_r + PTR_ONE;
            end
            if (in_pop && !in_empty) begin
                irp_r <= irp_r + PTR_ONE;
            end
            if (eg_pop && !eg_empty) begin
                erp_r <= erp_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/rd_rsp_route.sv
// Read-response router between engine, XHB and the AIDC decompressor.
// Each AR records whether its burst is compressed; R beats are steered to
// AIDC or straight to the engine, and decompressed beats are merged back in
// AR order. All data paths are combinational; only pointers/counters are flops.
// Optional macro CONNECT_RD_STAT_EN enables the per-tag burst counters.
module rd_rsp_route
    import connect_pkg::*;
#(
    parameter int PARAM = PARAM_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             CLK_i,
    input  logic             RST_i,
    input  logic             ENABLE_i,
    input  logic             ARVALID_i,
    input  logic             ARREADY_i,
    output logic             ARVALID_o,
    output logic             ARREADY_o,
    input  logic             RVALID_i,
    input  logic [PARAM-1:0] RDATA_i,
    input  logic             RLAST_i,
    output logic             RREADY_o,
    output logic             ERVALID_o,
    output logic [PARAM-1:0] ERDATA_o,
    output logic             ERLAST_o,
    input  logic             ERREADY_i,
    input  logic             CRVALID_i,
    input  logic [PARAM-1:0] CRDATA_i,
    input  logic             CRLAST_i,
    output logic             CRREADY_o,
    output logic             RVALID_o,
    output logic [PARAM-1:0] RDATA_o,
    output logic             RLAST_o,
    input  logic             RREADY_i,
    output logic [15:0]      STAT_CMP_o,
    output logic [15:0]      STAT_BYP_o
);

    logic full_s;
    logic in_empty_s;
    logic eg_empty_s;
    logic in_eg_same_s;
    tag_e in_tag_s;
    tag_e eg_tag_s;
    logic push_s;
    logic in_pop_s;
    logic eg_pop_s;

    logic arvalid_s;
    logic arready_s;
    logic rready_s;
    logic ervalid_s;
    logic crready_s;
    logic rvalid_s;

    rd_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk        (CLK_i),
        .rst        (RST_i),
        .push       (push_s),
        .push_tag   (tag_e'(ENABLE_i)),
        .in_pop     (in_pop_s),
        .eg_pop     (eg_pop_s),
        .full       (full_s),
        .in_empty   (in_empty_s),
        .eg_empty   (eg_empty_s),
        .in_eg_same (in_eg_same_s),
        .in_tag     (in_tag_s),
        .eg_tag     (eg_tag_s)
    );

    // Payload is passed through unconditionally; only valid/ready are steered.
    assign ERDATA_o = RDATA_i;
    assign ERLAST_o = RLAST_i;
    assign RDATA_o  = (eg_tag_s == TAG_CMP) ? CRDATA_i : RDATA_i;
    assign RLAST_o  = (eg_tag_s == TAG_CMP) ? CRLAST_i : RLAST_i;

    // Handshake steering by ingress and egress head tags; everything is
    // forced idle while reset is asserted.
    always_comb begin
        arvalid_s = 1'b0;
        arready_s = 1'b0;
        rready_s  = 1'b0;
        ervalid_s = 1'b0;
        crready_s = 1'b0;
        rvalid_s  = 1'b0;
        if (RST_i) begin
            arvalid_s = 1'b0;
        end else begin
            arvalid_s = ARVALID_i & ~full_s;
            arready_s = ARREADY_i & ~full_s;

            // Ingress: XHB beats belong to the burst at IRP.
            if (!in_empty_s) begin
                case (in_tag_s)
                    TAG_CMP: begin
                        ervalid_s = RVALID_i;
                        rready_s  = ERREADY_i;
                    end
                    TAG_BYP: begin
                        // A bypass burst may only pass once every compressed
                        // burst ahead of it has been delivered.
                        if (in_eg_same_s) begin
                            rvalid_s = RVALID_i;
                            rready_s = RREADY_i;
                        end else begin
                            rready_s = 1'b0;
                        end
                    end
                    default: begin
                        rready_s = 1'b0;
                    end
                endcase
            end else begin
                rready_s = 1'b0;
            end

            // Egress: a compressed head burst is sourced from AIDC.
            if (!eg_empty_s && (eg_tag_s == TAG_CMP)) begin
                rvalid_s  = CRVALID_i;
                crready_s = RREADY_i;
            end else begin
                crready_s = 1'b0;
            end
        end
    end

    assign ARVALID_o = arvalid_s;
    assign ARREADY_o = arready_s;
    assign RREADY_o  = rready_s;
    assign ERVALID_o = ervalid_s;
    assign CRREADY_o = crready_s;
    assign RVALID_o  = rvalid_s;

    assign push_s   = arvalid_s & ARREADY_i;
    assign in_pop_s = RVALID_i & rready_s & RLAST_i;
    assign eg_pop_s = rvalid_s & RREADY_i & RLAST_o;

`ifdef CONNECT_RD_STAT_EN
    logic [15:0] stat_cmp_r;
    logic [15:0] stat_byp_r;

    // Count bursts as they complete toward the engine, split by tag.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            stat_cmp_r <= 16'h0000;
            stat_byp_r <= 16'h0000;
        end else if (eg_pop_s) begin
            if (eg_tag_s == TAG_CMP) begin
                stat_cmp_r <= sat_inc16(stat_cmp_r);
            end else begin
                stat_byp_r <= sat_inc16(stat_byp_r);
            end
        end
    end

    assign STAT_CMP_o = stat_cmp_r;
    assign STAT_BYP_o = stat_byp_r;
`else
    assign STAT_CMP_o = 16'h0000;
    assign STAT_BYP_o = 16'h0000;
`endif

endmodule

// File: tb/tb_rd_rsp_route.sv
// Directed bench for rd_rsp_route: bypass, compressed, ordering, full,
// unsolicited beats and mid-burst reset.
module tb_rd_rsp_route;

    localparam int W = 32;
`ifdef CONNECT_RD_STAT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    logic         CLK_i = 1'b0;
    logic         RST_i = 1'b1;
    logic         ENABLE_i = 1'b0;
    logic         ARVALID_i = 1'b0;
    logic         ARREADY_i = 1'b0;
    logic         ARVALID_o;
    logic         ARREADY_o;
    logic         RVALID_i = 1'b0;
    logic [W-1:0] RDATA_i = '0;
    logic         RLAST_i = 1'b0;
    logic         RREADY_o;
    logic         ERVALID_o;
    logic [W-1:0] ERDATA_o;
    logic         ERLAST_o;
    logic         ERREADY_i = 1'b0;
    logic         CRVALID_i = 1'b0;
    logic [W-1:0] CRDATA_i = '0;
    logic         CRLAST_i = 1'b0;
    logic         CRREADY_o;
    logic         RVALID_o;
    logic [W-1:0] RDATA_o;
    logic         RLAST_o;
    logic         RREADY_i = 1'b0;
    logic [15:0]  STAT_CMP_o;
    logic [15:0]  STAT_BYP_o;

    int n_chk  = 0;
    int n_pass = 0;

    rd_rsp_route #(.PARAM(W), .DEPTH(8)) dut (
        .CLK_i(CLK_i), .RST_i(RST_i), .ENABLE_i(ENABLE_i),
        .ARVALID_i(ARVALID_i), .ARREADY_i(ARREADY_i),
        .ARVALID_o(ARVALID_o), .ARREADY_o(ARREADY_o),
        .RVALID_i(RVALID_i), .RDATA_i(RDATA_i), .RLAST_i(RLAST_i), .RREADY_o(RREADY_o),
        .ERVALID_o(ERVALID_o), .ERDATA_o(ERDATA_o), .ERLAST_o(ERLAST_o), .ERREADY_i(ERREADY_i),
        .CRVALID_i(CRVALID_i), .CRDATA_i(CRDATA_i), .CRLAST_i(CRLAST_i), .CRREADY_o(CRREADY_o),
        .RVALID_o(RVALID_o), .RDATA_o(RDATA_o), .RLAST_o(RLAST_o), .RREADY_i(RREADY_i),
        .STAT_CMP_o(STAT_CMP_o), .STAT_BYP_o(STAT_BYP_o)
    );

    always #5 CLK_i = ~CLK_i;

    // Inputs change right after the falling edge, outputs are sampled 2 ns later.
    task automatic drive_ar(input logic en);
        @(negedge CLK_i);
        ENABLE_i = en; ARVALID_i = 1'b1; ARREADY_i = 1'b1;
        #2;
        n_chk++;
        if (ARVALID_o !== 1'b1 || ARREADY_o !== 1'b1) $display("FAIL ar_accept: got v=%b r=%b want 1 1", ARVALID_o, ARREADY_o);
        else n_pass++;
        @(negedge CLK_i);
        ARVALID_i = 1'b0; ARREADY_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK_i);
        ARVALID_i = 1'b1; ARREADY_i = 1'b1; RVALID_i = 1'b1; CRVALID_i = 1'b1;
        RREADY_i = 1'b1; ERREADY_i = 1'b1;
        #2;
        n_chk++;
        if ({ARVALID_o, RREADY_o, ERVALID_o, CRREADY_o, RVALID_o} !== 5'b00000)
            $display("FAIL reset_outs: got %b want 00000", {ARVALID_o, RREADY_o, ERVALID_o, CRREADY_o, RVALID_o});
        else n_pass++;
        n_chk++;
        if (STAT_CMP_o !== 16'h0 || STAT_BYP_o !== 16'h0) $display("FAIL reset_stat: got %h %h want 0 0", STAT_CMP_o, STAT_BYP_o);
        else n_pass++;
        @(negedge CLK_i);
        RST_i = 1'b0; ARVALID_i = 1'b0; ARREADY_i = 1'b0; RVALID_i = 1'b0; CRVALID_i = 1'b0;
    endtask

    task automatic test_bypass();
        drive_ar(1'b0);
        for (int i = 1; i <= 4; i++) begin
            RVALID_i = 1'b1; RDATA_i = W'(i); RLAST_i = (i == 4); RREADY_i = 1'b1; ERREADY_i = 1'b1;
            #2;
            n_chk++;
            if (RVALID_o !== 1'b1 || RDATA_o !== W'(i) || RLAST_o !== (i == 4) || RREADY_o !== 1'b1 || ERVALID_o !== 1'b0)
                $display("FAIL byp_beat%0d: got v=%b d=%h l=%b rr=%b ev=%b want 1 %h %b 1 0", i, RVALID_o, RDATA_o, RLAST_o, RREADY_o, ERVALID_o, i, (i == 4));
            else n_pass++;
            @(negedge CLK_i);
        end
        RVALID_i = 1'b0; RLAST_i = 1'b0;
        #2;
        n_chk++;
        if (STAT_BYP_o !== (STAT_EN ? 16'd1 : 16'd0)) $display("FAIL byp_stat: got %0d want %0d", STAT_BYP_o, STAT_EN ? 1 : 0);
        else n_pass++;
    endtask

    task automatic test_compressed();
        drive_ar(1'b1);
        RVALID_i = 1'b1; RDATA_i = 32'h1; RLAST_i = 1'b0; ERREADY_i = 1'b0; RREADY_i = 1'b1;
        #2;
        n_chk++;
        if (RREADY_o !== 1'b0 || ERVALID_o !== 1'b1) $display("FAIL cmp_backpressure: got rr=%b ev=%b want 0 1", RREADY_o, ERVALID_o);
        else n_pass++;
        @(negedge CLK_i);
        for (int i = 1; i <= 4; i++) begin
            RVALID_i = 1'b1; RDATA_i = W'(i); RLAST_i = (i == 4); ERREADY_i = 1'b1;
            #2;
            n_chk++;
            if (ERVALID_o !== 1'b1 || ERDATA_o !== W'(i) || ERLAST_o !== (i == 4) || RREADY_o !== 1'b1 || RVALID_o !== 1'b0)
                $display("FAIL cmp_in_beat%0d: got ev=%b d=%h l=%b rr=%b rv=%b want 1 %h %b 1 0", i, ERVALID_o, ERDATA_o, ERLAST_o, RREADY_o, RVALID_o, i, (i == 4));
            else n_pass++;
            @(negedge CLK_i);
        end
        RVALID_i = 1'b0; RLAST_i = 1'b0;
        repeat (3) @(negedge CLK_i);
        for (int i = 0; i < 4; i++) begin
            CRVALID_i = 1'b1; CRDATA_i = 32'hA + W'(i); CRLAST_i = (i == 3);
            #2;
            n_chk++;
            if (RVALID_o !== 1'b1 || RDATA_o !== 32'hA + W'(i) || RLAST_o !== (i == 3) || CRREADY_o !== 1'b1)
                $display("FAIL cmp_out_beat%0d: got v=%b d=%h l=%b cr=%b want 1 %h %b 1", i, RVALID_o, RDATA_o, RLAST_o, CRREADY_o, 32'hA + i, (i == 3));
            else n_pass++;
            @(negedge CLK_i);
        end
        CRVALID_i = 1'b0; CRLAST_i = 1'b0;
        #2;
        n_chk++;
        if (STAT_CMP_o !== (STAT_EN ? 16'd1 : 16'd0) || CRREADY_o !== 1'b0) $display("FAIL cmp_stat: got %0d cr=%b want %0d 0", STAT_CMP_o, CRREADY_o, STAT_EN ? 1 : 0);
        else n_pass++;
    endtask

    task automatic test_order();
        drive_ar(1'b1);
        ENABLE_i = 1'b0; ARVALID_i = 1'b1; ARREADY_i = 1'b1;
        @(negedge CLK_i);
        ARVALID_i = 1'b0; ARREADY_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            RVALID_i = 1'b1; RDATA_i = 32'h10 + W'(i); RLAST_i = (i == 4); ERREADY_i = 1'b1;
            @(negedge CLK_i);
        end
        RVALID_i = 1'b1; RDATA_i = 32'h55; RLAST_i = 1'b0; RREADY_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #2;
            n_chk++;
            if (RREADY_o !== 1'b0 || RVALID_o !== 1'b0 || ERVALID_o !== 1'b0) $display("FAIL ord_hold%0d: got rr=%b rv=%b ev=%b want 0 0 0", k, RREADY_o, RVALID_o, ERVALID_o);
            else n_pass++;
            @(negedge CLK_i);
        end
        for (int i = 0; i < 4; i++) begin
            CRVALID_i = 1'b1; CRDATA_i = 32'h20 + W'(i); CRLAST_i = (i == 3);
            #2;
            n_chk++;
            if (RVALID_o !== 1'b1 || RDATA_o !== 32'h20 + W'(i) || RREADY_o !== 1'b0)
                $display("FAIL ord_cr%0d: got v=%b d=%h rr=%b want 1 %h 0", i, RVALID_o, RDATA_o, RREADY_o, 32'h20 + i);
            else n_pass++;
            @(negedge CLK_i);
        end
        CRVALID_i = 1'b0; CRLAST_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            RDATA_i = 32'h55 + W'(i); RLAST_i = (i == 1);
            #2;
            n_chk++;
            if (RREADY_o !== 1'b1 || RVALID_o !== 1'b1 || RDATA_o !== 32'h55 + W'(i))
                $display("FAIL ord_byp%0d: got rr=%b v=%b d=%h want 1 1 %h", i, RREADY_o, RVALID_o, RDATA_o, 32'h55 + i);
            else n_pass++;
            @(negedge CLK_i);
        end
        RVALID_i = 1'b0; RLAST_i = 1'b0;
        #2;
        n_chk++;
        if (STAT_CMP_o !== (STAT_EN ? 16'd2 : 16'd0) || STAT_BYP_o !== (STAT_EN ? 16'd2 : 16'd0))
            $display("FAIL ord_stat: got %0d %0d want %0d %0d", STAT_CMP_o, STAT_BYP_o, STAT_EN ? 2 : 0, STAT_EN ? 2 : 0);
        else n_pass++;
    endtask

    task automatic test_full();
        @(negedge CLK_i);
        ENABLE_i = 1'b0; ARVALID_i = 1'b1; ARREADY_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #2;
            n_chk++;
            if (ARREADY_o !== 1'b1) $display("FAIL full_ar%0d: got %b want 1", i, ARREADY_o);
            else n_pass++;
            @(negedge CLK_i);
        end
        #2;
        n_chk++;
        if (ARREADY_o !== 1'b0 || ARVALID_o !== 1'b0) $display("FAIL full_ar9: got r=%b v=%b want 0 0", ARREADY_o, ARVALID_o);
        else n_pass++;
        @(negedge CLK_i);
        RVALID_i = 1'b1; RDATA_i = 32'h100; RLAST_i = 1'b1; RREADY_i = 1'b1;
        #2;
        n_chk++;
        if (ARREADY_o !== 1'b0 || RVALID_o !== 1'b1) $display("FAIL full_pop_cycle: got ar=%b rv=%b want 0 1", ARREADY_o, RVALID_o);
        else n_pass++;
        @(negedge CLK_i);
        RVALID_i = 1'b0;
        #2;
        n_chk++;
        if (ARREADY_o !== 1'b1) $display("FAIL full_ar9_accept: got %b want 1", ARREADY_o);
        else n_pass++;
        @(negedge CLK_i);
        ARVALID_i = 1'b0; ARREADY_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            RVALID_i = 1'b1; RDATA_i = 32'h100 + W'(i); RLAST_i = 1'b1;
            #2;
            n_chk++;
            if (RVALID_o !== 1'b1 || RDATA_o !== 32'h100 + W'(i)) $display("FAIL full_drain%0d: got v=%b d=%h want 1 %h", i, RVALID_o, RDATA_o, 32'h100 + i);
            else n_pass++;
            @(negedge CLK_i);
        end
        #2;
        n_chk++;
        if (RREADY_o !== 1'b0 || RVALID_o !== 1'b0) $display("FAIL full_empty: got rr=%b rv=%b want 0 0", RREADY_o, RVALID_o);
        else n_pass++;
        n_chk++;
        if (STAT_BYP_o !== (STAT_EN ? 16'd11 : 16'd0)) $display("FAIL full_stat: got %0d want %0d", STAT_BYP_o, STAT_EN ? 11 : 0);
        else n_pass++;
        @(negedge CLK_i);
        RVALID_i = 1'b0; RLAST_i = 1'b0;
    endtask

    task automatic test_unsolicited();
        @(negedge CLK_i);
        RVALID_i = 1'b1; RDATA_i = 32'hDEAD; RLAST_i = 1'b1; RREADY_i = 1'b1; ERREADY_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #2;
            n_chk++;
            if (RREADY_o !== 1'b0 || RVALID_o !== 1'b0 || ERVALID_o !== 1'b0) $display("FAIL unsol%0d: got rr=%b rv=%b ev=%b want 0 0 0", k, RREADY_o, RVALID_o, ERVALID_o);
            else n_pass++;
            @(negedge CLK_i);
        end
        RVALID_i = 1'b0; RLAST_i = 1'b0;
    endtask

    task automatic test_midreset();
        drive_ar(1'b0);
        RVALID_i = 1'b1; RDATA_i = 32'h1; RLAST_i = 1'b0; RREADY_i = 1'b1;
        @(negedge CLK_i);
        RDATA_i = 32'h2; ARVALID_i = 1'b1; ARREADY_i = 1'b1;
        #2;
        RST_i = 1'b1;
        #1;
        n_chk++;
        if ({ARVALID_o, RREADY_o, ERVALID_o, CRREADY_o, RVALID_o} !== 5'b00000)
            $display("FAIL mid_rst_outs: got %b want 00000", {ARVALID_o, RREADY_o, ERVALID_o, CRREADY_o, RVALID_o});
        else n_pass++;
        n_chk++;
        if (STAT_CMP_o !== 16'h0 || STAT_BYP_o !== 16'h0) $display("FAIL mid_rst_stat: got %h %h want 0 0", STAT_CMP_o, STAT_BYP_o);
        else n_pass++;
        @(negedge CLK_i);
        RST_i = 1'b0; ARVALID_i = 1'b0; ARREADY_i = 1'b0; RDATA_i = 32'h3;
        #2;
        n_chk++;
        if (RREADY_o !== 1'b0 || RVALID_o !== 1'b0) $display("FAIL mid_rst_release: got rr=%b rv=%b want 0 0", RREADY_o, RVALID_o);
        else n_pass++;
        @(negedge CLK_i);
        RVALID_i = 1'b0;
        ARVALID_i = 1'b1; ARREADY_i = 1'b1;
        repeat (8) @(negedge CLK_i);
        #2;
        n_chk++;
        if (ARREADY_o !== 1'b0) $display("FAIL mid_rst_ptrs: 9th AR ready got %b want 0", ARREADY_o);
        else n_pass++;
        @(negedge CLK_i);
        ARVALID_i = 1'b0; ARREADY_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_compressed();
        test_order();
        test_full();
        test_unsolicited();
        test_midreset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
